sd_bit_source: RTL and testbench
================================

SD_BIT_SOURCE -- requirements
Module: sd_bit_source

Interface
REQ-001 Parameter WIDTH, default 10, maximum pattern length in bits (2..32).
REQ-002 Parameter LW, default $clog2(WIDTH+1), width of the length field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream offers a pattern word.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  pattern, bit 0 transmitted first.
REQ-008 in_len  input  LW  number of bits to send; 0 or >WIDTH means WIDTH.
REQ-009 stop  input  1  ends repeat mode; ignored unless repeat is compiled in.
REQ-010 o  output  1  serial bit to the sequence detector input i.
REQ-011 o_valid  output  1  o carries a pattern bit this cycle.
REQ-012 o_last  output  1  o carries the final bit of the pattern.
REQ-013 busy  output  1  a pattern is loaded and being shifted.

Function
REQ-014 FSM states IDLE and SHIFT: IDLE->SHIFT on accept; SHIFT->IDLE after last bit with no new accept; SHIFT->SHIFT on accept during last bit.
REQ-015 Accept = in_valid & in_ready; in_ready = 1 in IDLE, and 1 in SHIFT only in the cycle o_last = 1.
REQ-016 On accept, latch in_data and the effective length; the first bit (in_data[0]) appears on o in the next cycle; latency is 1 cycle.
REQ-017 In SHIFT, output one bit per cycle, bit k at cycle k after the first bit, k = 0..len-1, LSB first.
REQ-018 o_valid = 1 and busy = 1 throughout SHIFT; o_last = 1 only when bit index = len-1.
REQ-019 An accept during the o_last cycle starts the new pattern in the next cycle with no bubble; o_valid stays 1.
REQ-020 In IDLE: o = 0, o_valid = 0, o_last = 0, busy = 0.
REQ-021 in_len = 1: a single-cycle pattern with o_valid and o_last both high in the same cycle.
REQ-022 in_data and in_len changes while not accepting have no effect on the output.
REQ-023 The bit index counter is LW bits wide; it resets to 0 on every accept and on every repeat wrap.

Reset
REQ-024 rst high at a clock edge forces IDLE, index 0, and all outputs 0 except in_ready, which is 1 in the next cycle.
REQ-025 Reset mid-pattern discards the remaining bits; no o_last is produced for the aborted pattern.
REQ-026 rst has priority over accept and over repeat in the same cycle.

Configuration
REQ-027 Macro SD_BIT_SOURCE_REPEAT_EN defined: after the last bit, if no accept and stop = 0, restart at bit 0 of the latched word next cycle; o_last pulses every pass.
REQ-028 With the macro defined, stop = 1 in the o_last cycle returns the block to IDLE; stop sampled in other cycles is ignored; an accept in the o_last cycle overrides the repeat.
REQ-029 Macro not defined: no repeat; stop has no effect; behaviour is REQ-014..023 only.

Structure
REQ-030 Shared package sd_pkg holds the state enum (IDLE, SHIFT), the WIDTH default constant, and the effective-length helper function.
REQ-031 One sub-module, sd_shift_reg (loadable WIDTH-bit right-shift register with load and shift enables), holds the pattern; the FSM, counter and handshake stay in sd_bit_source.

Verification
REQ-032 Reset, then in_data=10'b0001101011, in_len=10, one accept -> o = 1,1,0,1,0,1,1,0,0,0 over 10 cycles starting 1 cycle after accept; o_last on the 10th bit; then IDLE.
REQ-033 in_len=0 with the same word -> identical to REQ-032; in_len=1, in_data[0]=1 -> one cycle with o=1, o_valid=1, o_last=1.
REQ-034 Back-to-back: second word 10'b1111100000 held valid during the first pattern -> accepted in the o_last cycle; 20 contiguous o_valid cycles, no gap.
REQ-035 rst asserted at bit 4 of a 10-bit pattern -> next cycle o_valid=0, busy=0, in_ready=1; no o_last seen.
REQ-036 With SD_BIT_SOURCE_REPEAT_EN defined, in_len=3, in_data=3'b011 -> o = 1,1,0,1,1,0,... until stop=1 in an o_last cycle, then IDLE next cycle.
REQ-037 Without the macro, stop held at 0 with the same stimulus -> a single pass, then IDLE.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the serial pattern source.
//   state_t       : FSM state encoding (IDLE, SHIFT)
//   WIDTH_DEFAULT : default maximum pattern length in bits
//   eff_len()     : maps a requested length to the length actually sent
package sd_pkg;

    localparam int unsigned WIDTH_DEFAULT = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length of 0, or one longer than the register, means "send the whole word".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/sd_shift_reg.sv
// Loadable right-shift register holding the pattern; bit 0 is the bit on the wire.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears the register
//   load  : load din (has priority over shift)
//   shift : shift right by one, zero fill from the top
//   din   : word to load
//   q     : register contents
module sd_shift_reg
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sd_bit_source.sv
// Serialises pattern words LSB first towards a sequence detector, one bit per cycle.
// Optional build macro SD_BIT_SOURCE_REPEAT_EN: replay the latched word until stop is
// seen in an o_last cycle.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : pattern word handshake
//   in_data, in_len    : pattern word and its length (0 or >WIDTH means WIDTH)
//   stop               : ends repeat mode (repeat build only)
//   o, o_valid, o_last : serial bit, bit-valid, final-bit marker
//   busy               : a pattern is being shifted
module sd_bit_source
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    input  logic             stop,
    output logic             o,
    output logic             o_valid,
    output logic             o_last,
    output logic             busy
);

    state_t           state_q;
    logic [LW-1:0]    idx_q;
    logic [LW-1:0]    len_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    new_len;
    logic             last;
    logic             accept;
    logic             wrap;
    logic             load;
    logic             shift;

    assign last     = (state_q == SHIFT) && (idx_q == (len_q - LW'(1)));
    assign in_ready = (state_q == IDLE) || last;
    assign accept   = in_valid && in_ready;
    assign new_len  = LW'(eff_len(32'(in_len), WIDTH));

`ifdef SD_BIT_SOURCE_REPEAT_EN
    // Copy of the accepted word, used to refill the shift register on every pass.
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (accept) begin
            word_q <= in_data;
        end
    end

    // A new accept overrides the replay; stop only matters in the final-bit cycle.
    assign wrap      = last && !accept && !stop;
    assign load_data = accept ? in_data : word_q;
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign wrap        = 1'b0;
    assign load_data   = in_data;
`endif

    assign load  = accept || wrap;
    assign shift = (state_q == SHIFT) && !last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        idx_q   <= '0;
                        len_q   <= new_len;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        idx_q <= '0;
                        len_q <= new_len;
                    end else if (wrap) begin
                        idx_q <= '0;
                    end else if (last) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + LW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sd_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (load_data),
        .q     (sr_q)
    );

    assign o       = (state_q == SHIFT) && sr_q[0];
    assign o_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign o_last  = last;

endmodule

// File: tb/tb_sd_bit_source.sv
// Self-checking bench for sd_bit_source: a negedge monitor pops expected bits from a
// scoreboard filled whenever the bench sees a word being accepted.
module tb_sd_bit_source;

    localparam int W    = 10;
    localparam int LWID = $clog2(W + 1);

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            in_valid = 1'b0;
    logic            stop     = 1'b1;
    logic [W-1:0]    in_data  = '0;
    logic [LWID-1:0] in_len   = '0;
    logic            in_ready;
    logic            o;
    logic            o_valid;
    logic            o_last;
    logic            busy;

    sd_bit_source #(
        .WIDTH (W),
        .LW    (LWID)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .stop     (stop),
        .o        (o),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t     sb[$];
    int       checks    = 0;
    int       errors    = 0;
    bit       mon_en    = 1'b0;
    int       cur_run   = 0;
    int       last_run  = 0;
    int       last_seen = 0;
    logic [W-1:0] cur_data = '0;
    int       cur_len   = 0;
    exp_t     mon_e;
    logic     mon_have;
    logic     exp_rdy;
    logic     exp_vld;

    function automatic int model_len(input int l);
        return ((l == 0) || (l > W)) ? W : l;
    endfunction

    function automatic void push_pattern(input logic [W-1:0] d, input int l);
        for (int i = 0; i < l; i++) begin
            exp_t e;
            e.b    = d[i];
            e.last = (i == l - 1);
            sb.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: compare the current cycle, then record what the next edge will start.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_vld = (sb.size() != 0);
            exp_rdy = 1'b1;
            if (exp_vld) exp_rdy = sb[0].last;
            chk("in_ready", in_ready, exp_rdy);
            chk("o_valid", o_valid, exp_vld);
            chk("busy", busy, exp_vld);
            mon_have = 1'b0;
            if (exp_vld) begin
                mon_e    = sb.pop_front();
                mon_have = 1'b1;
                chk("o", o, mon_e.b);
                chk("o_last", o_last, mon_e.last);
            end else begin
                chk("o_idle", o, 1'b0);
                chk("o_last_idle", o_last, 1'b0);
            end
            if (o_valid === 1'b1) begin
                cur_run++;
            end else if (cur_run != 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (o_last === 1'b1) last_seen++;
            if (rst) begin
                sb.delete();
            end else if (in_valid && exp_rdy) begin
                cur_data = in_data;
                cur_len  = model_len(int'(in_len));
                push_pattern(cur_data, cur_len);
            end
`ifdef SD_BIT_SOURCE_REPEAT_EN
            else if (mon_have && mon_e.last && !stop) begin
                push_pattern(cur_data, cur_len);
            end
`endif
        end
    end

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [LWID-1:0] l);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        wait_ready("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Changes while not accepting must not disturb the pattern in flight.
        in_data  = W'($urandom);
        in_len   = LWID'($urandom);
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Full 10-bit word, stop held high to show it is ignored in the default build.
        send(10'b0001101011, 4'd10);
        drain("drain_t1");
        chk_int("run_len10", last_run, 10);

        // Length 0 means full width.
        send(10'b0001101011, 4'd0);
        drain("drain_len0");
        chk_int("run_len0", last_run, 10);

        // Single-bit pattern.
        send(10'b1010101011, 4'd1);
        drain("drain_len1");
        chk_int("run_len1", last_run, 1);

        // Length above WIDTH means full width.
        send(10'b1100110010, 4'd15);
        drain("drain_len15");
        chk_int("run_len15", last_run, 10);

        // Back-to-back: second word held valid, accepted in the o_last cycle.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 10'b0001101011;
        in_len   = 4'd10;
        wait_ready("b2b_first");
        @(posedge clk);
        #1;
        in_data  = 10'b1111100000;
        in_len   = 4'd10;
        wait_ready("b2b_second");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("drain_b2b");
        chk_int("run_b2b", last_run, 20);

        // Reset while bit 4 is on the wire.
        ls0 = last_seen;
        send(10'b0101010101, 4'd10);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_o_valid", o_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        drain("drain_abort");
        chk_int("abort_no_last", last_seen - ls0, 0);
        chk_int("abort_run", last_run, 5);

        // Three-bit word with stop low.
        stop = 1'b0;
        send(10'b0000000011, 4'd3);
`ifdef SD_BIT_SOURCE_REPEAT_EN
        repeat (7) @(posedge clk);
        #1;
        stop = 1'b1;
        drain("drain_repeat");
        chk("repeat_idle", o_valid, 1'b0);
`else
        drain("drain_once");
        chk_int("run_once", last_run, 3);
        chk("once_idle", o_valid, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
